// File: rtl/ysyx_23060203_rf_wb_sched_pkg.sv
// Shared types for the RF write-back scheduler: address/data widths and the write-back request record.
// Latency and back-pressure are not applicable; this package holds only types and a helper function.
package ysyx_23060203_rf_wb_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    xdata_t    data;
  } wb_req_t;

  // Out-of-range register numbers are folded onto x0 so they never touch a counter.
  function automatic reg_addr_t legal_rd(input reg_addr_t rd, input int nr_reg);
    return (int'(rd) < nr_reg) ? rd : '0;
  endfunction

endpackage

// File: rtl/ysyx_23060203_rf_wb_sched_if.sv
// Issue/hazard query, two write-back request channels and the registered RF write port.
// master drives requests and queries; slave (the scheduler) returns readies, hazard and the RF write.
interface ysyx_23060203_rf_wb_sched_if;
  import ysyx_23060203_rf_wb_sched_pkg::*;

  logic      iss_valid;
  reg_addr_t iss_rd;
  logic      iss_ready;

  reg_addr_t chk_rs1;
  reg_addr_t chk_rs2;
  logic      chk_hazard;

  logic      wb0_valid;
  reg_addr_t wb0_rd;
  xdata_t    wb0_data;
  logic      wb0_ready;

  logic      wb1_valid;
  reg_addr_t wb1_rd;
  xdata_t    wb1_data;
  logic      wb1_ready;

  logic      rf_wen;
  reg_addr_t rf_waddr;
  xdata_t    rf_wdata;

  modport master (
    output iss_valid, iss_rd, chk_rs1, chk_rs2,
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  iss_ready, chk_hazard, wb0_ready, wb1_ready,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output iss_ready, chk_hazard, wb0_ready, wb1_ready,
    output rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/ysyx_23060203_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from req, pointer moves only on a completed handshake.
// Zero latency; a lone requester always wins, on contention the side not granted last wins.
module ysyx_23060203_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       handshake,
  output logic [1:0] gnt
);

  // last1_q = 1 means requester 1 was granted last, so requester 0 is favoured next.
  logic last1_q, last1_d;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = last1_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last1_d = last1_q;
    if (handshake) begin
      last1_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last1_q <= 1'b1;
    end else begin
      last1_q <= last1_d;
    end
  end

endmodule

// File: rtl/ysyx_23060203_rf_wb_sched.sv
// RF write-back scheduler: round-robin wb0/wb1 onto one registered RF write port plus a pending-write scoreboard.
// Latency 1 from handshake to rf_wen; the write port never back-pressures, issue stalls on a saturated rd counter.
module ysyx_23060203_rf_wb_sched
  import ysyx_23060203_rf_wb_sched_pkg::*;
#(
  parameter int NR_REG = 16,
  parameter int CNT_W  = 2
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_23060203_rf_wb_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  reg_addr_t iss_rd_s, rs1_s, rs2_s;
  wb_req_t   req0, req1;
  logic [1:0] arb_req, arb_gnt, wb_rdy;
  logic      wb_hs;
  reg_addr_t sel_rd;
  xdata_t    sel_data;

  logic [CNT_W-1:0] cnt_q [1:NR_REG-1];
  logic [CNT_W-1:0] cnt_d [1:NR_REG-1];
  logic [CNT_W-1:0] iss_cnt, rs1_cnt, rs2_cnt, ret_cnt;
  logic             iss_ready, iss_fire;

  logic      rf_wen_q, rf_wen_d;
  reg_addr_t rf_waddr_q, rf_waddr_d;
  xdata_t    rf_wdata_q, rf_wdata_d;

  assign iss_rd_s = legal_rd(bus.iss_rd, NR_REG);
  assign rs1_s    = legal_rd(bus.chk_rs1, NR_REG);
  assign rs2_s    = legal_rd(bus.chk_rs2, NR_REG);

  always_comb begin
    req0.valid = bus.wb0_valid;
    req0.rd    = legal_rd(bus.wb0_rd, NR_REG);
    req0.data  = bus.wb0_data;
    req1.valid = bus.wb1_valid;
    req1.rd    = legal_rd(bus.wb1_rd, NR_REG);
    req1.data  = bus.wb1_data;
  end

  assign arb_req = {req1.valid, req0.valid};

  ysyx_23060203_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .handshake (wb_hs),
    .gnt       (arb_gnt)
  );

  // Ready depends only on valids and the pointer; forced low while reset is held.
  assign wb_rdy        = rst ? 2'b00 : arb_gnt;
  assign wb_hs         = |wb_rdy;
  assign bus.wb0_ready = wb_rdy[0];
  assign bus.wb1_ready = wb_rdy[1];

  assign sel_rd   = wb_rdy[1] ? req1.rd   : req0.rd;
  assign sel_data = wb_rdy[1] ? req1.data : req0.data;

  // x0 has no counter; every lookup of it reads as zero.
  always_comb begin
    iss_cnt = '0;
    rs1_cnt = '0;
    rs2_cnt = '0;
    ret_cnt = '0;
    for (int i = 1; i < NR_REG; i++) begin
      if (iss_rd_s == REG_ADDR_W'(i))   iss_cnt = cnt_q[i];
      if (rs1_s == REG_ADDR_W'(i))      rs1_cnt = cnt_q[i];
      if (rs2_s == REG_ADDR_W'(i))      rs2_cnt = cnt_q[i];
      if (rf_waddr_q == REG_ADDR_W'(i)) ret_cnt = cnt_q[i];
    end
  end

  assign iss_ready      = !rst && (iss_cnt != CNT_MAX);
  assign iss_fire       = bus.iss_valid && iss_ready && (iss_rd_s != '0);
  assign bus.iss_ready  = iss_ready;
  assign bus.chk_hazard = (rs1_cnt != '0) || (rs2_cnt != '0);

  // Retirement happens on the same edge the RF captures the data.
  always_comb begin
    for (int i = 1; i < NR_REG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (iss_fire && (iss_rd_s == REG_ADDR_W'(i)) &&
          !(rf_wen_q && (rf_waddr_q == REG_ADDR_W'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (rf_wen_q && (rf_waddr_q == REG_ADDR_W'(i)) &&
                   !(iss_fire && (iss_rd_s == REG_ADDR_W'(i))) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rf_wen_d   = wb_hs && (sel_rd != '0);
    rf_waddr_d = rf_wen_d ? sel_rd   : '0;
    rf_wdata_d = rf_wen_d ? sel_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NR_REG; i++) begin
        cnt_q[i] <= '0;
      end
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      for (int i = 1; i < NR_REG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // Protocol errors: retiring a register with nothing pending, or naming a register that does not exist.
  ast_no_underflow: assert property (@(posedge clk) disable iff (rst)
    rf_wen_q |-> (ret_cnt != '0));
  ast_iss_rd_range: assert property (@(posedge clk) disable iff (rst)
    bus.iss_valid |-> (int'(bus.iss_rd) < NR_REG));
  ast_wb0_rd_range: assert property (@(posedge clk) disable iff (rst)
    bus.wb0_valid |-> (int'(bus.wb0_rd) < NR_REG));
  ast_wb1_rd_range: assert property (@(posedge clk) disable iff (rst)
    bus.wb1_valid |-> (int'(bus.wb1_rd) < NR_REG));

endmodule

// File: tb/tb_ysyx_23060203_rf_wb_sched.sv
// Bench for the RF write-back scheduler: vector table, corner-case sequences and a randomized run
// against a counting model of issued, handed-off and retired writes per register.
module tb_ysyx_23060203_rf_wb_sched;
  import ysyx_23060203_rf_wb_sched_pkg::*;

  localparam int NREG   = 16;
  localparam int MAXCNT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060203_rf_wb_sched_if bus ();

  ysyx_23060203_rf_wb_sched #(.NR_REG(NREG), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int pend  [NREG];
  int outst [NREG];

  typedef struct {
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic        w0v;
    logic [4:0]  w0rd;
    logic [31:0] w0d;
    logic        w1v;
    logic [4:0]  w1rd;
    logic [31:0] w1d;
    logic [3:0]  e4;
    logic        ewen;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  vec_t tv [16];

  function automatic vec_t mkv(input logic iv, input logic [4:0] ird, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic w0v, input logic [4:0] w0rd,
                               input logic [31:0] w0d, input logic w1v, input logic [4:0] w1rd,
                               input logic [31:0] w1d, input logic [3:0] e4, input logic ewen,
                               input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.w0v = w0v; v.w0rd = w0rd; v.w0d = w0d;
    v.w1v = w1v; v.w1rd = w1rd; v.w1d = w1d;
    v.e4 = e4; v.ewen = ewen; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0;
    bus.wb0_valid = 1'b0; bus.wb0_rd = '0; bus.wb0_data = '0;
    bus.wb1_valid = 1'b0; bus.wb1_rd = '0; bus.wb1_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] cands[$];
    for (int r = 1; r < NREG; r++) if (outst[r] > 0) cands.push_back(5'(r));
    if (cands.size() == 0 || $urandom_range(0, 7) == 0) return 5'd0;
    return cands[$urandom_range(0, cands.size() - 1)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        iv, w0v, w1v, g0, g1, e_ir, e_hz, e_wen, last_wb1;
    logic [4:0]  ird, rs1, rs2, w0rd, w1rd, hrd, e_wa;
    logic [31:0] w0d, w1d, e_wd;

    // ---------------- reset state ----------------
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd2;
    bus.wb0_valid = 1'b1; bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd1;
    rst = 1'b1;
    tick();
    check("rst_rf_wen", bus.rf_wen, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_wb0_ready", bus.wb0_ready, 0);
    check("rst_wb1_ready", bus.wb1_ready, 0);
    check("rst_iss_ready", bus.iss_ready, 0);
    do_reset();

    // ---------------- vector table ----------------
    //          iv ird  rs1  rs2  w0v w0rd w0d            w1v w1rd w1d            {ir,hz,r0,r1} wen wa  wd
    tv[0]  = mkv(1, 5'd1, 5'd1, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1000, 0, 5'd0, 32'h0);
    tv[1]  = mkv(1, 5'd2, 5'd1, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1100, 0, 5'd0, 32'h0);
    tv[2]  = mkv(1, 5'd3, 5'd0, 5'd2, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1100, 0, 5'd0, 32'h0);
    tv[3]  = mkv(1, 5'd4, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1000, 0, 5'd0, 32'h0);
    tv[4]  = mkv(0, 5'd0, 5'd1, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 4'b1110, 1, 5'd1, 32'h11111111);
    tv[5]  = mkv(0, 5'd0, 5'd1, 5'd0, 1, 5'd3, 32'h33333333, 1, 5'd2, 32'h22222222, 4'b1101, 1, 5'd2, 32'h22222222);
    tv[6]  = mkv(0, 5'd0, 5'd1, 5'd0, 1, 5'd3, 32'h33333333, 1, 5'd4, 32'h44444444, 4'b1010, 1, 5'd3, 32'h33333333);
    tv[7]  = mkv(0, 5'd0, 5'd0, 5'd3, 1, 5'd3, 32'h33333333, 1, 5'd4, 32'h44444444, 4'b1101, 1, 5'd4, 32'h44444444);
    tv[8]  = mkv(0, 5'd0, 5'd4, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1100, 0, 5'd0, 32'h0);
    tv[9]  = mkv(0, 5'd0, 5'd4, 5'd3, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1000, 0, 5'd0, 32'h0);
    tv[10] = mkv(1, 5'd5, 5'd5, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1000, 0, 5'd0, 32'h0);
    tv[11] = mkv(0, 5'd0, 5'd5, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        4'b1110, 1, 5'd5, 32'hDEADBEEF);
    tv[12] = mkv(0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1100, 0, 5'd0, 32'h0);
    tv[13] = mkv(0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b1000, 0, 5'd0, 32'h0);
    tv[14] = mkv(1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,     4'b1001, 0, 5'd0, 32'h0);
    tv[15] = mkv(1, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'h5555,     1, 5'd0, 32'h1234,     4'b1010, 0, 5'd0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      bus.iss_valid = tv[i].iv; bus.iss_rd = tv[i].ird;
      bus.chk_rs1 = tv[i].rs1; bus.chk_rs2 = tv[i].rs2;
      bus.wb0_valid = tv[i].w0v; bus.wb0_rd = tv[i].w0rd; bus.wb0_data = tv[i].w0d;
      bus.wb1_valid = tv[i].w1v; bus.wb1_rd = tv[i].w1rd; bus.wb1_data = tv[i].w1d;
      #1;
      check($sformatf("tv%0d_iss_ready", i), bus.iss_ready, tv[i].e4[3]);
      check($sformatf("tv%0d_hazard", i), bus.chk_hazard, tv[i].e4[2]);
      check($sformatf("tv%0d_wb0_ready", i), bus.wb0_ready, tv[i].e4[1]);
      check($sformatf("tv%0d_wb1_ready", i), bus.wb1_ready, tv[i].e4[0]);
      tick();
      check($sformatf("tv%0d_rf_wen", i), bus.rf_wen, tv[i].ewen);
      if (tv[i].ewen) begin
        check($sformatf("tv%0d_rf_waddr", i), bus.rf_waddr, tv[i].ewa);
        check($sformatf("tv%0d_rf_wdata", i), bus.rf_wdata, tv[i].ewd);
      end
    end

    // ---------------- reset mid-traffic ----------------
    do_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    tick();
    bus.iss_rd = 5'd1;
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd5; bus.wb0_data = 32'hCAFE0005;
    bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd0;
    #1;
    check("mid_wb0_ready_pre", bus.wb0_ready, 1);
    rst = 1'b1;
    #1;
    check("mid_wb0_ready", bus.wb0_ready, 0);
    check("mid_wb1_ready", bus.wb1_ready, 0);
    check("mid_iss_ready", bus.iss_ready, 0);
    tick();
    check("mid_rf_wen", bus.rf_wen, 0);
    rst = 1'b0;
    idle();
    bus.chk_rs1 = 5'd5;
    #1;
    check("mid_hazard_rs1_5", bus.chk_hazard, 0);
    tick();
    check("mid_rf_wen_after", bus.rf_wen, 0);

    // ---------------- counter saturation ----------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
      #1;
      check($sformatf("sat_iss_ready_%0d", k), bus.iss_ready, 1);
      tick();
    end
    #1;
    check("sat_full_0", bus.iss_ready, 0);
    tick();
    check("sat_full_1", bus.iss_ready, 0);
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd3; bus.wb0_data = 32'h0000A5A5;
    #1;
    check("sat_full_2", bus.iss_ready, 0);
    check("sat_wb0_ready", bus.wb0_ready, 1);
    tick();
    bus.wb0_valid = 1'b0;
    check("sat_rf_wen", bus.rf_wen, 1);
    check("sat_rf_waddr", bus.rf_waddr, 3);
    #1;
    check("sat_full_retiring", bus.iss_ready, 0);
    tick();
    check("sat_freed", bus.iss_ready, 1);
    tick();
    check("sat_full_again", bus.iss_ready, 0);

    // ---------------- issue and retire on the same edge ----------------
    do_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd7; bus.wb0_data = 32'h77;
    #1;
    check("same_wb0_ready", bus.wb0_ready, 1);
    tick();
    bus.wb0_valid = 1'b0;
    check("same_rf_wen", bus.rf_wen, 1);
    check("same_rf_waddr", bus.rf_waddr, 7);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    check("same_iss_ready", bus.iss_ready, 1);
    tick();
    bus.iss_valid = 1'b0; bus.chk_rs2 = 5'd7;
    #1;
    check("same_hazard_0", bus.chk_hazard, 1);
    tick();
    check("same_hazard_1", bus.chk_hazard, 1);
    bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd7; bus.wb1_data = 32'h78;
    tick();
    bus.wb1_valid = 1'b0;
    check("same_rf_wen_2", bus.rf_wen, 1);
    check("same_rf_wdata_2", bus.rf_wdata, 32'h78);
    tick();
    check("same_hazard_clear", bus.chk_hazard, 0);

    // ---------------- randomized run against the counting model ----------------
    do_reset();
    for (int r = 0; r < NREG; r++) begin pend[r] = 0; outst[r] = 0; end
    last_wb1 = 1'b1;
    e_wen = 1'b0; e_wa = '0; e_wd = '0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_rf_wen", bus.rf_wen, e_wen);
      if (e_wen) begin
        check("rnd_rf_waddr", bus.rf_waddr, e_wa);
        check("rnd_rf_wdata", bus.rf_wdata, e_wd);
      end
      iv   = 1'($urandom_range(0, 1));
      ird  = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      w0v  = ($urandom_range(0, 9) < 6);
      w0rd = pick_rd();
      w0d  = $urandom;
      w1v  = ($urandom_range(0, 9) < 6);
      w1rd = pick_rd();
      w1d  = $urandom;
      bus.iss_valid = iv; bus.iss_rd = ird; bus.chk_rs1 = rs1; bus.chk_rs2 = rs2;
      bus.wb0_valid = w0v; bus.wb0_rd = w0rd; bus.wb0_data = w0d;
      bus.wb1_valid = w1v; bus.wb1_rd = w1rd; bus.wb1_data = w1d;
      #1;
      e_ir = (ird == 0) || (pend[ird] < MAXCNT);
      e_hz = (rs1 != 0 && pend[rs1] != 0) || (rs2 != 0 && pend[rs2] != 0);
      g0   = w0v && (!w1v || last_wb1);
      g1   = w1v && (!w0v || !last_wb1);
      check("rnd_iss_ready", bus.iss_ready, e_ir);
      check("rnd_hazard", bus.chk_hazard, e_hz);
      check("rnd_wb0_ready", bus.wb0_ready, g0);
      check("rnd_wb1_ready", bus.wb1_ready, g1);
      if (e_wen) pend[e_wa]--;
      if (iv && e_ir && ird != 0) begin
        pend[ird]++;
        outst[ird]++;
      end
      e_wen = 1'b0;
      if (g0 || g1) begin
        last_wb1 = g1;
        hrd = g1 ? w1rd : w0rd;
        if (hrd != 0) begin
          outst[hrd]--;
          e_wen = 1'b1;
          e_wa  = hrd;
          e_wd  = g1 ? w1d : w0d;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
